// File: rtl/nd_loop_iter.sv
// Handshaked N-dimensional loop iterator: one index vector per valid/ready beat.
// Optional abort input/flag enabled by defining ND_LOOP_ITER_ABORT_EN.
module nd_loop_iter #(
  parameter int unsigned BW     = 8,
  parameter int unsigned DIM    = 2,
  parameter int unsigned CNT_BW = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cfg_valid,
  output logic                o_cfg_ready,
  input  logic [DIM*BW-1:0]   i_beg,
  input  logic [DIM*BW-1:0]   i_stride,
  input  logic [DIM*BW-1:0]   i_end,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [DIM*BW-1:0]   o_idx,
  output logic [DIM*BW-1:0]   o_ofs,
  output logic [DIM-1:0]      o_last_mask,
  output logic                o_last,
  output logic [CNT_BW-1:0]   o_beat,
`ifdef ND_LOOP_ITER_ABORT_EN
  input  logic                i_abort,
  output logic                o_aborted,
`endif
  output logic                o_done
);

  localparam int unsigned VW = DIM * BW;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              r_state;
  logic [VW-1:0]       r_beg;
  logic [VW-1:0]       r_stride;
  logic [VW-1:0]       r_end;
  logic [VW-1:0]       r_idx;
  logic [VW-1:0]       r_ofs;
  logic [DIM-1:0]      r_mask;
  logic                r_last;
  logic [CNT_BW-1:0]   r_beat;
  logic                r_valid;
  logic                r_done;
  logic                r_cfg_ready;

  logic                w_fire;
  logic                w_abort;
  logic                w_empty;
  logic [DIM-1:0]      w_step;
  logic [VW-1:0]       w_nxt_idx;
  logic [VW-1:0]       w_nxt_ofs;
  logic [DIM-1:0]      w_nxt_mask;
  logic [DIM-1:0]      w_cfg_mask;

  // Per-dimension "next step lands on end" flags.
  function automatic logic [DIM-1:0] f_mask(input logic [VW-1:0] idx,
                                            input logic [VW-1:0] stride,
                                            input logic [VW-1:0] e);
    logic [DIM-1:0] m;
    m = '0;
    for (int unsigned d = 0; d < DIM; d++) begin
      m[d] = (BW'(idx[d*BW +: BW] + stride[d*BW +: BW]) == e[d*BW +: BW]);
    end
    return m;
  endfunction

`ifdef ND_LOOP_ITER_ABORT_EN
  assign w_abort = i_abort & (r_state == S_RUN);
`else
  assign w_abort = 1'b0;
`endif

  // Innermost-first carry chain and next index/offset.
  always_comb begin
    w_fire    = r_valid & i_ready;
    w_step    = '0;
    w_step[DIM-1] = 1'b1;
    for (int d = int'(DIM) - 2; d >= 0; d--) begin
      w_step[d] = w_step[d+1] & r_mask[d+1];
    end
    w_nxt_idx = r_idx;
    w_nxt_ofs = r_ofs;
    for (int unsigned d = 0; d < DIM; d++) begin
      if (w_step[d]) begin
        if (r_mask[d]) begin
          w_nxt_idx[d*BW +: BW] = r_beg[d*BW +: BW];
          w_nxt_ofs[d*BW +: BW] = '0;
        end else begin
          w_nxt_idx[d*BW +: BW] = BW'(r_idx[d*BW +: BW] + r_stride[d*BW +: BW]);
          w_nxt_ofs[d*BW +: BW] = BW'(r_ofs[d*BW +: BW] + r_stride[d*BW +: BW]);
        end
      end
    end
    w_empty = 1'b0;
    for (int unsigned d = 0; d < DIM; d++) begin
      if (i_beg[d*BW +: BW] == i_end[d*BW +: BW]) w_empty = 1'b1;
    end
    w_nxt_mask = f_mask(w_nxt_idx, r_stride, r_end);
    w_cfg_mask = f_mask(i_beg, i_stride, i_end);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_beg       <= '0;
      r_stride    <= '0;
      r_end       <= '0;
      r_idx       <= '0;
      r_ofs       <= '0;
      r_mask      <= '0;
      r_last      <= 1'b0;
      r_beat      <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cfg_valid && r_cfg_ready) begin
            r_beg    <= i_beg;
            r_stride <= i_stride;
            r_end    <= i_end;
            r_idx    <= i_beg;
            r_ofs    <= '0;
            r_beat   <= '0;
            r_mask   <= w_cfg_mask;
            r_last   <= &w_cfg_mask;
            if (w_empty) begin
              r_done <= 1'b1;
            end else begin
              r_state     <= S_RUN;
              r_valid     <= 1'b1;
              r_cfg_ready <= 1'b0;
            end
          end
        end
        S_RUN: begin
          // A beat firing alongside abort still counts as delivered.
          if (w_abort || (w_fire && r_last)) begin
            r_state     <= S_IDLE;
            r_valid     <= 1'b0;
            r_done      <= 1'b1;
            r_cfg_ready <= 1'b1;
          end else if (w_fire) begin
            r_idx  <= w_nxt_idx;
            r_ofs  <= w_nxt_ofs;
            r_mask <= w_nxt_mask;
            r_last <= &w_nxt_mask;
            r_beat <= r_beat + CNT_BW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ND_LOOP_ITER_ABORT_EN
  logic r_aborted;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_aborted <= 1'b0;
    else        r_aborted <= w_abort;
  end

  assign o_aborted = r_aborted;
`endif

  assign o_cfg_ready = r_cfg_ready;
  assign o_valid     = r_valid;
  assign o_idx       = r_idx;
  assign o_ofs       = r_ofs;
  assign o_last_mask = r_mask;
  assign o_last      = r_last;
  assign o_beat      = r_beat;
  assign o_done      = r_done;

endmodule

// File: tb/tb_nd_loop_iter.sv
// Directed self-checking bench for nd_loop_iter (DIM=2, BW=8).
module tb_nd_loop_iter;

  localparam int unsigned BW     = 8;
  localparam int unsigned DIM    = 2;
  localparam int unsigned CNT_BW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [DIM*BW-1:0] beg;
  logic [DIM*BW-1:0] stride;
  logic [DIM*BW-1:0] endv;
  logic              valid;
  logic              ready;
  logic [DIM*BW-1:0] idx;
  logic [DIM*BW-1:0] ofs;
  logic [DIM-1:0]    last_mask;
  logic              last;
  logic [CNT_BW-1:0] beat;
  logic              done;
`ifdef ND_LOOP_ITER_ABORT_EN
  logic              abort;
  logic              aborted;
`endif

  int checks   = 0;
  int failures = 0;

  nd_loop_iter #(.BW(BW), .DIM(DIM), .CNT_BW(CNT_BW)) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_cfg_valid (cfg_valid),
    .o_cfg_ready (cfg_ready),
    .i_beg       (beg),
    .i_stride    (stride),
    .i_end       (endv),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_idx       (idx),
    .o_ofs       (ofs),
    .o_last_mask (last_mask),
    .o_last      (last),
    .o_beat      (beat),
`ifdef ND_LOOP_ITER_ABORT_EN
    .i_abort     (abort),
    .o_aborted   (aborted),
`endif
    .o_done      (done)
  );

  always #5 clk = ~clk;

  // Arguments are (dim0, dim1) pairs; dim1 is the innermost dimension.
  task automatic cfg_set(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] e0, input logic [7:0] e1);
    beg    = {b1, b0};
    stride = {s1, s0};
    endv   = {e1, e0};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_valid = 1'b0; ready = 1'b1;
    cfg_set(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
`ifdef ND_LOOP_ITER_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({valid, done, cfg_ready, last} !== 4'b0010) begin
      failures++; $display("FAIL reset_flags got=%b exp=0010", {valid, done, cfg_ready, last});
    end
    checks++;
    if ({idx, ofs, last_mask, beat} !== '0) begin
      failures++; $display("FAIL reset_data got=%h/%h/%b/%h exp=0", idx, ofs, last_mask, beat);
    end
  endtask

  task automatic test_basic();
    int n;
    cfg_set(8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3);
    cfg_valid = 1'b1; ready = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    n = 0;
    for (int a = 0; a < 2; a++) begin
      for (int b = 0; b < 3; b++) begin
        checks++;
        if ({valid, cfg_ready} !== 2'b10) begin
          failures++; $display("FAIL basic_valid beat=%0d got=%b exp=10", n, {valid, cfg_ready});
        end
        checks++;
        if (idx !== {8'(b), 8'(a)} || ofs !== {8'(b), 8'(a)}) begin
          failures++; $display("FAIL basic_idx beat=%0d got=%h/%h exp=%h", n, idx, ofs, {8'(b), 8'(a)});
        end
        checks++;
        if (last_mask !== {1'(b == 2), 1'(a == 1)} || last !== 1'(a == 1 && b == 2)) begin
          failures++; $display("FAIL basic_mask beat=%0d got=%b/%b exp=%b/%b", n, last_mask, last,
                               {1'(b == 2), 1'(a == 1)}, 1'(a == 1 && b == 2));
        end
        checks++;
        if (beat !== CNT_BW'(n)) begin
          failures++; $display("FAIL basic_beat got=%0d exp=%0d", beat, n);
        end
        @(negedge clk);
        n++;
      end
    end
    checks++;
    if ({valid, done, cfg_ready} !== 3'b011) begin
      failures++; $display("FAIL basic_done got=%b exp=011", {valid, done, cfg_ready});
    end
    @(negedge clk);
    checks++;
    if ({valid, done} !== 2'b00) begin
      failures++; $display("FAIL basic_done_pulse got=%b exp=00", {valid, done});
    end
  endtask

  task automatic test_stride();
    cfg_set(8'd4, 8'd10, 8'd2, 8'd5, 8'd8, 8'd20);
    cfg_valid = 1'b1; ready = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (valid !== 1'b1 || idx !== {8'(10 + 5 * (k % 2)), 8'(4 + 2 * (k / 2))}) begin
        failures++; $display("FAIL stride_idx k=%0d got=%b/%h exp=1/%h", k, valid, idx,
                             {8'(10 + 5 * (k % 2)), 8'(4 + 2 * (k / 2))});
      end
      checks++;
      if (ofs !== {8'(5 * (k % 2)), 8'(2 * (k / 2))} || last !== 1'(k == 3)) begin
        failures++; $display("FAIL stride_ofs k=%0d got=%h/%b exp=%h/%b", k, ofs, last,
                             {8'(5 * (k % 2)), 8'(2 * (k / 2))}, 1'(k == 3));
      end
      @(negedge clk);
    end
    checks++;
    if ({valid, done} !== 2'b01) begin
      failures++; $display("FAIL stride_done got=%b exp=01", {valid, done});
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    int n;
    logic [3:0] pat;
    pat = 4'b1001;
    cfg_set(8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3);
    cfg_valid = 1'b1; ready = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      ready = pat[3 - (cyc % 4)];
      if (valid) begin
        checks++;
        if (idx !== {8'(n % 3), 8'(n / 3)} || ofs !== {8'(n % 3), 8'(n / 3)} ||
            beat !== CNT_BW'(n) || last_mask !== {1'(n % 3 == 2), 1'(n / 3 == 1)}) begin
          failures++; $display("FAIL stall_hold cyc=%0d got=%h/%h/%0d/%b exp_beat=%0d", cyc, idx, ofs,
                               beat, last_mask, n);
        end
        if (ready) n++;
      end
      @(negedge clk);
      if (n == 6) break;
    end
    checks++;
    if (n !== 6 || {valid, done} !== 2'b01) begin
      failures++; $display("FAIL stall_count got=%0d/%b exp=6/01", n, {valid, done});
    end
    ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_empty();
    cfg_set(8'd0, 8'd7, 8'd1, 8'd1, 8'd2, 8'd7);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++;
    if ({valid, done, cfg_ready} !== 3'b011) begin
      failures++; $display("FAIL empty_done got=%b exp=011", {valid, done, cfg_ready});
    end
    @(negedge clk);
    checks++;
    if ({valid, done, cfg_ready} !== 3'b001) begin
      failures++; $display("FAIL empty_after got=%b exp=001", {valid, done, cfg_ready});
    end
  endtask

  task automatic test_back_to_back();
    cfg_set(8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd3);
    cfg_valid = 1'b1; ready = 1'b1;
    @(negedge clk);
    // Second config held from here on: must be ignored until the done cycle.
    cfg_set(8'd0, 8'd5, 8'd1, 8'd1, 8'd1, 8'd7);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({valid, cfg_ready} !== 2'b10 || idx !== {8'(k), 8'd0} || last !== 1'(k == 2)) begin
        failures++; $display("FAIL b2b_job1 k=%0d got=%b/%h/%b exp=10/%h/%b", k, {valid, cfg_ready},
                             idx, last, {8'(k), 8'd0}, 1'(k == 2));
      end
      @(negedge clk);
    end
    checks++;
    if ({valid, done, cfg_ready} !== 3'b011) begin
      failures++; $display("FAIL b2b_done got=%b exp=011", {valid, done, cfg_ready});
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (valid !== 1'b1 || idx !== {8'(5 + k), 8'd0} || beat !== CNT_BW'(k) || done !== 1'b0) begin
        failures++; $display("FAIL b2b_job2 k=%0d got=%b/%h/%0d exp=1/%h/%0d", k, valid, idx, beat,
                             {8'(5 + k), 8'd0}, k);
      end
      @(negedge clk);
    end
    checks++;
    if ({valid, done} !== 2'b01) begin
      failures++; $display("FAIL b2b_done2 got=%b exp=01", {valid, done});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    cfg_set(8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3);
    cfg_valid = 1'b1; ready = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (idx !== {8'd0, 8'd1} || beat !== CNT_BW'(3)) begin
      failures++; $display("FAIL rstmid_pre got=%h/%0d exp=0001/3", idx, beat);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, done, cfg_ready, last} !== 4'b0010 || {idx, ofs, last_mask, beat} !== '0) begin
      failures++; $display("FAIL rstmid_async got=%b/%h/%0d exp=0010/0/0", {valid, done, cfg_ready, last},
                           idx, beat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({valid, done, cfg_ready} !== 3'b001) begin
        failures++; $display("FAIL rstmid_after k=%0d got=%b exp=001", k, {valid, done, cfg_ready});
      end
    end
  endtask

`ifdef ND_LOOP_ITER_ABORT_EN
  task automatic test_abort();
    cfg_set(8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3);
    cfg_valid = 1'b1; ready = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({valid, done, aborted, cfg_ready} !== 4'b0111) begin
      failures++; $display("FAIL abort_pulse got=%b exp=0111", {valid, done, aborted, cfg_ready});
    end
    @(negedge clk);
    checks++;
    if ({valid, done, aborted} !== 3'b000) begin
      failures++; $display("FAIL abort_after got=%b exp=000", {valid, done, aborted});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stride();
    test_stall();
    test_empty();
    test_back_to_back();
    test_reset_mid();
`ifdef ND_LOOP_ITER_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
